// File: rtl/mux_n_to_1_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_to_1_pipe
// Purpose  : N-to-1 multiplexer with a single registered output stage and
//            valid/ready handshakes on every input channel and on the output.
//            MODE 0 selects the channel named by sel. MODE 1 arbitrates
//            round-robin among the valid channels and ignores sel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous reset, active low
//   in_data    in   N_INPUTS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N_INPUTS        channel i presents data
//   in_ready   out  N_INPUTS        channel i accepted this cycle (combinational)
//   sel        in   SEL_W           channel select (MODE 0 only)
//   out_data   out  WIDTH           registered selected data
//   out_valid  out  1               out_data holds a valid word
//   out_ready  in   1               consumer accepts out_data
//   out_src    out  SEL_W           channel that produced out_data
// ============================================================================
module mux_n_to_1_pipe #(
  parameter  int WIDTH    = 32,
  parameter  int N_INPUTS = 4,
  parameter  int MODE     = 0,
  localparam int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_valid,
  output logic [N_INPUTS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_src
);

  // Channel count widened by one bit so that index arithmetic and range
  // checks never overflow, whether or not N_INPUTS is a power of two.
  localparam logic [SEL_W:0]   C_N_EXT = (SEL_W+1)'(N_INPUTS);
  localparam logic [SEL_W-1:0] C_LAST  = SEL_W'(N_INPUTS - 1);

  logic [WIDTH-1:0]    w_ch [N_INPUTS];
  logic [SEL_W-1:0]    w_grant;
  logic                w_grant_ok;
  logic [N_INPUTS-1:0] w_gnt_oh;
  logic [N_INPUTS-1:0] w_in_ready;
  logic                w_load_en;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_sel_data;

  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_out_src;

  // --------------------------------------------------------------------------
  // Unpack the flattened input bus into one word per channel.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
    assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // Grant selection.
  // --------------------------------------------------------------------------
  if (MODE == 0) begin : g_mode_sel
    // The grant follows sel directly, independent of in_valid; an index
    // past the last channel grants nothing.
    always_comb begin
      w_grant    = sel;
      w_grant_ok = ({1'b0, sel} < C_N_EXT);
    end
  end else begin : g_mode_rr
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W:0]   w_idx;
    logic             w_unused_sel;

    assign w_unused_sel = ^sel;

    // Scan the channels starting at the pointer and take the first valid
    // one. The wrap is a subtraction rather than a mask so non power-of-two
    // channel counts stay correct.
    always_comb begin
      w_grant    = '0;
      w_grant_ok = 1'b0;
      w_idx      = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
        w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
        if (w_idx >= C_N_EXT) begin
          w_idx = w_idx - C_N_EXT;
        end
        if (!w_grant_ok && in_valid[w_idx[SEL_W-1:0]]) begin
          w_grant_ok = 1'b1;
          w_grant    = w_idx[SEL_W-1:0];
        end
      end
    end

    // The pointer moves just past the channel that was served, so that
    // channel becomes lowest priority on the next scan.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rr_ptr <= '0;
      end else if (w_xfer) begin
        r_rr_ptr <= (w_grant == C_LAST) ? '0 : w_grant + SEL_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // One-hot grant, handshake and data select.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_gnt_oh
    assign w_gnt_oh[i] = w_grant_ok && (w_grant == SEL_W'(i));
  end

  // The output register can take a word when it is empty or being drained
  // in this same cycle; out_ready therefore reaches in_ready combinationally.
  assign w_load_en  = !r_out_valid || out_ready;

  // rst_n gates in_ready so no producer sees an accept while in reset.
  assign w_in_ready = w_gnt_oh & {N_INPUTS{w_load_en && rst_n}};
  assign w_xfer     = |(in_valid & w_in_ready);

  // At most one grant bit is set, so a plain scan is a clean AND-OR mux.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_data = w_ch[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register. Data and source only change on a transfer, so both hold
  // through stalls and after a drain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: doc/mux_n_to_1_pipe.md
Name: mux_n_to_1_pipe

Overview:
Parametrised N-to-1 multiplexer with one registered output stage and valid/ready handshakes on every input and on the output. Next generation of the datapath 2:1 selector. Used where several producers share one consumer: register-file write-back source, PC source, and a future multi-cycle/pipelined datapath. Two modes: explicit select (driven by control unit) and round-robin arbitration.

Parameters:
WIDTH, 32, data width of each input and of the output
N_INPUTS, 4, number of input channels (>=2)
MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration, sel ignored
SEL_W, $clog2(N_INPUTS), select/source index width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
in_data  input  N_INPUTS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
in_valid  input  N_INPUTS  channel i has data
in_ready  output  N_INPUTS  channel i transfer accepted this cycle (combinational)
sel  input  SEL_W  channel select, MODE 0 only
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds valid data
out_ready  input  1  consumer accepts out_data
out_src  output  SEL_W  index of channel that produced out_data

Behaviour:
- Reset: one clock; rst_n asynchronous, active low. While rst_n=0: out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready=0 for all channels.
- Reset mid-operation drops the held word. No transfer completes in the cycle rst_n deasserts unless the handshake is met at that edge.
- load_en = !out_valid || out_ready. Combinational path from out_ready to in_ready is permitted. No skid buffer.
- Grant g, combinational:
  - MODE 0: g = sel, valid only if sel < N_INPUTS. If sel >= N_INPUTS, nothing is granted and all in_ready=0.
  - MODE 1: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_INPUTS. None valid means no grant.
- in_ready[i] = load_en && (i == g) && grant_exists. All other bits are 0.
  - MODE 0: in_ready[sel] may be 1 while in_valid[sel]=0.
  - MODE 1: in_ready is asserted only to a valid channel.
- Transfer: in_valid[g] && in_ready[g]. At the next rising edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
- Drain without load: out_valid && out_ready with no transfer gives out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: out_valid stays 1, new data is loaded. Full throughput is 1 word/cycle.
- Stall: out_valid && !out_ready holds out_data and out_src stable and forces in_ready=0.
- rr_ptr (MODE 1 only):
  - After a transfer from g, rr_ptr <= g+1, wrapping from N_INPUTS-1 to 0.
  - Unchanged when there is no transfer.
  - N_INPUTS need not be a power of 2; the wrap is explicit.
- Latency: 1 cycle from input transfer to out_valid.
- sel must be stable while in_valid[sel] is waiting. A change of sel moves the grant in the same cycle; no data is corrupted.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111, out_ready=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0. Release rst_n -> first transfer appears at the next edge.
- MODE 0 streaming: sel=2, channel 2 presents 0xA0..0xA7 with in_valid=1, out_ready=1 -> out_data=0xA0..0xA7 on consecutive cycles, 1-cycle latency, out_src=2, in_ready=4'b0100.
- MODE 0 backpressure: out_ready=0 for 3 cycles after 0x11 loaded -> out_data holds 0x11 and in_ready=0. out_ready=1 -> 0x22 loads at the same edge 0x11 drains; no loss or duplicate.
- MODE 0 invalid select with N_INPUTS=3: sel=3 -> in_ready=0, out_valid falls after the drain.
- MODE 1 fairness: all 4 channels valid continuously, out_ready=1 -> out_src sequence is 0,1,2,3,0,1...
- MODE 1 sparse: only channels 1 and 3 valid, rr_ptr=2 -> grant order 3,1,3,1.
- MODE 1 mid-operation reset: reset with rr_ptr=3 -> rr_ptr=0 and out_valid=0; the first grant after release goes to the lowest valid channel.
